cpu_commit_tracker: RTL

- Downstream consumer of the CPU monitor interface signals.
- Watches the write-back stage and turns each retired instruction into a sequenced commit record.
- Buffers records in a small FIFO and hands them to the scoreboard over a valid/ready handshake.
- Tracks run phase and flags stalls (no commit for too long), FIFO overflow and CPU fault indication.

---
 rtl/cpu_commit_tracker.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_commit_tracker.sv
// cpu_commit_tracker
// Watches the CPU write-back stage and turns every retiring instruction into a
// sequenced commit record. Records are queued in a first-word-fall-through
// FIFO and handed to the consumer over a valid/ready handshake. The block also
// tracks run phase, flags a commit watchdog stall, counts commits dropped on
// FIFO overflow, and latches the PC of the first CPU fault seen while running.
module cpu_commit_tracker #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SEQ_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_flag,
  input  logic             run_finished,
  input  logic             indication,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic [31:0]      wb_instr,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [SEQ_W-1:0] rec_seq,
  output logic [31:0]      rec_pc,
  output logic [31:0]      rec_instr,
  output logic             rec_we,
  output logic [4:0]       rec_rd,
  output logic [31:0]      rec_data,
  output logic [1:0]       phase,
  output logic             stall_timeout,
  output logic             overflow_err,
  output logic [7:0]       drop_count,
  output logic             fault_seen,
  output logic [31:0]      fault_pc
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_RUN     = 2'd1,
    PH_DONE    = 2'd2,
    PH_STALLED = 2'd3
  } phase_e;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             we;
    logic [4:0]       rd;
    logic [31:0]      data;
  } rec_t;

  // FIFO storage and pointers
  rec_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Sequencing, watchdog and status
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [WDW-1:0]   wd_q, wd_d;
  phase_e           state_q, state_d;
  logic             stall_q, stall_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;
  logic             fault_seen_q, fault_seen_d;
  logic [31:0]      fault_pc_q, fault_pc_d;
  logic             ind_prev_q, ind_prev_d;

  // Combinational helpers
  logic             in_run;
  logic             cap;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             wd_expire;
  rec_t             push_rec;
  rec_t             head;

  // Phase state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= PH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase next-state: finishing wins over a watchdog expiry in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_IDLE: begin
        if (run_flag) state_d = PH_RUN;
      end
      PH_RUN: begin
        if (run_finished)   state_d = PH_DONE;
        else if (wd_expire) state_d = PH_STALLED;
      end
      default: state_d = state_q;
    endcase
  end

  // Phase outputs decoded from the registered state
  always_comb begin
    in_run = (state_q == PH_RUN);
    phase  = state_q;
  end

  // Capture, FIFO control and status next-state
  always_comb begin
    cap       = in_run && wb_valid;
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    pop       = !empty && rec_ready;
    // A full FIFO can still take a commit when the head leaves this cycle
    push      = cap && (!full || pop);
    drop      = cap && full && !pop;
    // Dropped commits still prove the CPU is alive, so they also feed the watchdog
    wd_expire = in_run && !cap && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

    push_rec.seq   = seq_q;
    push_rec.pc    = wb_pc;
    push_rec.instr = wb_instr;
    push_rec.we    = wb_reg_write && (wb_rd != 5'd0);
    push_rec.rd    = wb_rd;
    push_rec.data  = wb_data;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Sequence numbers only advance on commits that actually land in the FIFO
    seq_d = push ? seq_q + SEQ_W'(1) : seq_q;

    wd_d = wd_q;
    if (state_d != PH_RUN || !in_run) wd_d = '0;
    else if (cap)                     wd_d = '0;
    else                              wd_d = wd_q + WDW'(1);

    stall_d = stall_q || (in_run && state_d == PH_STALLED);
    ovf_d   = ovf_q || drop;
    drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    ind_prev_d   = indication;
    fault_seen_d = fault_seen_q;
    fault_pc_d   = fault_pc_q;
    if (in_run && indication && !ind_prev_q && !fault_seen_q) begin
      fault_seen_d = 1'b1;
      fault_pc_d   = wb_pc;
    end
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      seq_q        <= '0;
      wd_q         <= '0;
      stall_q      <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= '0;
      fault_seen_q <= 1'b0;
      fault_pc_q   <= '0;
      ind_prev_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      seq_q        <= seq_d;
      wd_q         <= wd_d;
      stall_q      <= stall_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      fault_seen_q <= fault_seen_d;
      fault_pc_q   <= fault_pc_d;
      ind_prev_q   <= ind_prev_d;
    end
  end

  // Record storage; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_rec;
  end

  // Head record presented straight from storage, zeroed while the FIFO is empty
  always_comb begin
    head      = mem_q[rd_ptr_q];
    rec_valid = !empty;
    rec_seq   = rec_valid ? head.seq   : '0;
    rec_pc    = rec_valid ? head.pc    : '0;
    rec_instr = rec_valid ? head.instr : '0;
    rec_we    = rec_valid ? head.we    : 1'b0;
    rec_rd    = rec_valid ? head.rd    : '0;
    rec_data  = rec_valid ? head.data  : '0;
  end

  assign stall_timeout = stall_q;
  assign overflow_err  = ovf_q;
  assign drop_count    = drop_q;
  assign fault_seen    = fault_seen_q;
  assign fault_pc      = fault_pc_q;

endmodule
